// File: rtl/prefix_adder_pkg.sv
// Shared types and elaboration helpers for the pipelined Kogge-Stone adder.
// The latency helper is the single source of truth for both RTL and benches.
package prefix_adder_pkg;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    // Number of Kogge-Stone levels needed to span `width` bits.
    function automatic int unsigned clog2_levels(input int unsigned width);
        int unsigned lv;
        lv = 0;
        for (int unsigned i = 0; i < 8; i++) begin
            if ((32'd1 << i) < width) begin
                lv = i + 1;
            end
        end
        return lv;
    endfunction

    function automatic int unsigned pipe_latency(input int unsigned width,
                                                 input int unsigned pipe_every);
        if (pipe_every == 0) begin
            return 1;
        end
        return 1 + (clog2_levels(width) - 1) / pipe_every;
    endfunction

    // A stage register sits after level k when k is a multiple of the spacing,
    // except after the last level where the output register already sits.
    function automatic bit stage_reg(input int unsigned level, input int unsigned levels,
                                     input int unsigned pipe_every);
        return (pipe_every != 0) && (level % pipe_every == 0) && (level < levels);
    endfunction

    function automatic bit params_legal(input int unsigned width, input int unsigned tag_w);
        return (width >= 2) && (width <= 128) && (tag_w >= 1) && (tag_w <= 32);
    endfunction

    function automatic gp_t gp_combine(input gp_t hi, input gp_t lo);
        gp_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = hi.p & lo.p;
        return r;
    endfunction

endpackage

// File: rtl/prefix_level.sv
// One Kogge-Stone prefix level, optionally followed by a stage register that
// also carries the original propagate vector, carry-in, tag and valid bit.
module prefix_level
    import prefix_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DIST  = 1,
    parameter bit          REG   = 1'b0,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             adv_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] g_i,
    input  logic [WIDTH-1:0] p_i,
    input  logic [WIDTH-1:0] pv_i,
    input  logic             c0_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] g_o,
    output logic [WIDTH-1:0] p_o,
    output logic [WIDTH-1:0] pv_o,
    output logic             c0_o,
    output logic [TAG_W-1:0] tag_o
);

    logic [WIDTH-1:0] g_d;
    logic [WIDTH-1:0] p_d;

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
        if (i >= int'(DIST)) begin : g_comb
            gp_t gp;
            assign gp     = gp_combine({g_i[i], p_i[i]},
                                       {g_i[i - int'(DIST)], p_i[i - int'(DIST)]});
            assign g_d[i] = gp.g;
            assign p_d[i] = gp.p;
        end else begin : g_pass
            assign g_d[i] = g_i[i];
            assign p_d[i] = p_i[i];
        end
    end

    if (REG) begin : g_reg
        logic             valid_q;
        logic [WIDTH-1:0] g_q;
        logic [WIDTH-1:0] p_q;
        logic [WIDTH-1:0] pv_q;
        logic             c0_q;
        logic [TAG_W-1:0] tag_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                valid_q <= 1'b0;
            end else if (adv_i) begin
                valid_q <= valid_i;
            end
        end

        // Datapath carries no reset; only the valid bit qualifies it.
        always_ff @(posedge clk_i) begin
            if (adv_i) begin
                g_q   <= g_d;
                p_q   <= p_d;
                pv_q  <= pv_i;
                c0_q  <= c0_i;
                tag_q <= tag_i;
            end
        end

        assign valid_o = valid_q;
        assign g_o     = g_q;
        assign p_o     = p_q;
        assign pv_o    = pv_q;
        assign c0_o    = c0_q;
        assign tag_o   = tag_q;
    end else begin : g_wire
        logic unused_ctrl;
        assign unused_ctrl = ^{clk_i, rst_ni, adv_i};

        assign valid_o = valid_i;
        assign g_o     = g_d;
        assign p_o     = p_d;
        assign pv_o    = pv_i;
        assign c0_o    = c0_i;
        assign tag_o   = tag_i;
    end

endmodule

// File: rtl/prefix_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready streaming, carry-in,
// signed overflow and a sideband tag; one global advance drives every stage.
module prefix_adder_pipe
    import prefix_adder_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned PIPE_EVERY = 2,
    parameter int unsigned TAG_W      = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    input  logic             sub_i,
    input  logic [TAG_W-1:0] in_tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o,
    output logic [TAG_W-1:0] out_tag_o
);

    localparam int unsigned LEVELS = clog2_levels(WIDTH);

    if (!params_legal(WIDTH, TAG_W)) begin : g_bad_params
        $fatal(1, "prefix_adder_pipe: WIDTH must be 2..128 and TAG_W 1..32");
    end

    logic adv;
    logic out_valid_q;

    // Combinational out_ready -> in_ready path: the whole pipe moves as one.
    assign adv        = !out_valid_q || out_ready_i;
    assign in_ready_o = adv;

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] p0;
    logic [WIDTH-1:0] g0;
    logic             c0;

    always_comb begin
        b_eff = sub_i ? ~b_i : b_i;
        c0    = sub_i | cin_i;
        p0    = a_i ^ b_eff;
        g0    = a_i & b_eff;
        g0[0] = g0[0] | (p0[0] & c0);
    end

    for (genvar k = 1; k <= int'(LEVELS); k++) begin : g_lvl
        logic             valid_in;
        logic             valid_out;
        logic             c0_in;
        logic             c0_out;
        logic [WIDTH-1:0] g_in;
        logic [WIDTH-1:0] p_in;
        logic [WIDTH-1:0] pv_in;
        logic [WIDTH-1:0] g_out;
        logic [WIDTH-1:0] p_out;
        logic [WIDTH-1:0] pv_out;
        logic [TAG_W-1:0] tag_in;
        logic [TAG_W-1:0] tag_out;

        if (k == 1) begin : g_first
            assign valid_in = in_valid_i;
            assign g_in     = g0;
            assign p_in     = p0;
            assign pv_in    = p0;
            assign c0_in    = c0;
            assign tag_in   = in_tag_i;
        end else begin : g_chain
            assign valid_in = g_lvl[k-1].valid_out;
            assign g_in     = g_lvl[k-1].g_out;
            assign p_in     = g_lvl[k-1].p_out;
            assign pv_in    = g_lvl[k-1].pv_out;
            assign c0_in    = g_lvl[k-1].c0_out;
            assign tag_in   = g_lvl[k-1].tag_out;
        end

        prefix_level #(
            .WIDTH (WIDTH),
            .DIST  (32'd1 << (k - 1)),
            .REG   (stage_reg(k, LEVELS, PIPE_EVERY)),
            .TAG_W (TAG_W)
        ) u_level (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .adv_i   (adv),
            .valid_i (valid_in),
            .g_i     (g_in),
            .p_i     (p_in),
            .pv_i    (pv_in),
            .c0_i    (c0_in),
            .tag_i   (tag_in),
            .valid_o (valid_out),
            .g_o     (g_out),
            .p_o     (p_out),
            .pv_o    (pv_out),
            .c0_o    (c0_out),
            .tag_o   (tag_out)
        );
    end

    logic             valid_fin;
    logic             c0_fin;
    logic [WIDTH-1:0] g_fin;
    logic [WIDTH-1:0] pv_fin;
    logic [TAG_W-1:0] tag_fin;
    logic             unused_p;

    assign valid_fin = g_lvl[LEVELS].valid_out;
    assign c0_fin    = g_lvl[LEVELS].c0_out;
    assign g_fin     = g_lvl[LEVELS].g_out;
    assign pv_fin    = g_lvl[LEVELS].pv_out;
    assign tag_fin   = g_lvl[LEVELS].tag_out;
    assign unused_p  = ^g_lvl[LEVELS].p_out;

    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic             ovf_d;

    // G[i] is the carry out of bit i, so it is also the carry into bit i+1.
    always_comb begin
        sum_d  = pv_fin ^ {g_fin[WIDTH-2:0], c0_fin};
        cout_d = g_fin[WIDTH-1];
        ovf_d  = g_fin[WIDTH-2] ^ g_fin[WIDTH-1];
    end

    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic [TAG_W-1:0] tag_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
        end else if (adv) begin
            out_valid_q <= valid_fin;
        end
    end

    always_ff @(posedge clk_i) begin
        if (adv) begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
            tag_q  <= tag_fin;
        end
    end

    assign out_valid_o = out_valid_q;
    assign sum_o       = sum_q;
    assign cout_o      = cout_q;
    assign ovf_o       = ovf_q;
    assign out_tag_o   = tag_q;

endmodule

// File: tb/tb_prefix_adder_pipe.sv
// Directed and streamed checks of prefix_adder_pipe: a 32-bit instance with
// spacing 2, plus three 4-bit instances (spacing 0, 1, 2) swept exhaustively.
module tb_prefix_adder_pipe;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic [3:0]  tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic [3:0]  out_tag;

    logic        v4;
    logic [3:0]  a4;
    logic [3:0]  b4;
    logic        cin4;
    logic        sub4;
    logic [3:0]  tag4;
    logic        unused_ir4 [3];
    logic        vo4 [3];
    logic [3:0]  s4 [3];
    logic        co4 [3];
    logic        ov4 [3];
    logic [3:0]  to4 [3];

    int checks = 0;
    int passes = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    prefix_adder_pipe #(
        .WIDTH      (32),
        .PIPE_EVERY (2),
        .TAG_W      (4)
    ) u_dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .a_i         (a),
        .b_i         (b),
        .cin_i       (cin),
        .sub_i       (sub),
        .in_tag_i    (in_tag),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .sum_o       (sum),
        .cout_o      (cout),
        .ovf_o       (ovf),
        .out_tag_o   (out_tag)
    );

    for (genvar d = 0; d < 3; d++) begin : g_w4
        prefix_adder_pipe #(
            .WIDTH      (4),
            .PIPE_EVERY (d),
            .TAG_W      (4)
        ) u_dut4 (
            .clk_i       (clk),
            .rst_ni      (rst_n),
            .in_valid_i  (v4),
            .in_ready_o  (unused_ir4[d]),
            .a_i         (a4),
            .b_i         (b4),
            .cin_i       (cin4),
            .sub_i       (sub4),
            .in_tag_i    (tag4),
            .out_valid_o (vo4[d]),
            .out_ready_i (1'b1),
            .sum_o       (s4[d]),
            .cout_o      (co4[d]),
            .ovf_o       (ov4[d]),
            .out_tag_o   (to4[d])
        );
    end

    task automatic check(input string nm, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else $error("FAIL %s: observed %0h expected %0h", nm, obs, expv);
    endtask

    function automatic exp_t model32(input logic [31:0] va, input logic [31:0] vb,
                                     input logic vcin, input logic vsub, input logic [3:0] vtag);
        logic [31:0] be;
        logic [32:0] r;
        exp_t e;
        be     = vsub ? ~vb : vb;
        r      = {1'b0, va} + {1'b0, be} + {32'd0, (vsub | vcin)};
        e.sum  = r[31:0];
        e.cout = r[32];
        e.ovf  = (va[31] == be[31]) && (r[31] != va[31]);
        e.tag  = vtag;
        return e;
    endfunction

    // Returns {ovf, cout, sum} for exhaustive index j = {sub, cin, b, a}.
    function automatic logic [5:0] model4(input int j);
        logic [3:0] va;
        logic [3:0] be;
        logic [4:0] r;
        logic       vs;
        va = j[3:0];
        vs = j[9];
        be = vs ? ~j[7:4] : j[7:4];
        r  = {1'b0, va} + {1'b0, be} + {4'd0, (vs | j[8])};
        return {(va[3] == be[3]) && (r[3] != va[3]), r[4], r[3:0]};
    endfunction

    // One cycle of the 32-bit stream: score outputs, record accepted inputs.
    task automatic tick(output logic accepted);
        exp_t e;
        #1;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("spurious_out", 64'(out_valid), 64'(0));
            end else begin
                e = sb.pop_front();
                check("res_sum", 64'(sum), 64'(e.sum));
                check("res_cout", 64'(cout), 64'(e.cout));
                check("res_ovf", 64'(ovf), 64'(e.ovf));
                check("res_tag", 64'(out_tag), 64'(e.tag));
            end
        end
        accepted = in_valid && in_ready;
        if (accepted) sb.push_back(model32(a, b, cin, sub, in_tag));
        @(posedge clk);
        #1;
    endtask

    // Single beat into an empty pipe; result must appear exactly 3 cycles later.
    task automatic directed(input string nm, input logic [31:0] va, input logic [31:0] vb,
                            input logic vcin, input logic vsub, input logic [3:0] vtag,
                            input logic [31:0] esum, input logic ecout, input logic eovf);
        a        = va;
        b        = vb;
        cin      = vcin;
        sub      = vsub;
        in_tag   = vtag;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 1; i < 3; i++) begin
            #1;
            check({nm, "_early"}, 64'(out_valid), 64'(0));
            @(posedge clk);
            #1;
        end
        #1;
        check({nm, "_valid"}, 64'(out_valid), 64'(1));
        check({nm, "_sum"}, 64'(sum), 64'(esum));
        check({nm, "_cout"}, 64'(cout), 64'(ecout));
        check({nm, "_ovf"}, 64'(ovf), 64'(eovf));
        check({nm, "_tag"}, 64'(out_tag), 64'(vtag));
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic        acc;
        logic [31:0] r;
        int          idx;
        int          j;
        int          lat4 [3];
        logic [5:0]  m;

        lat4      = '{1, 2, 1};
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        in_tag    = '0;
        out_ready = 1'b1;
        v4        = 1'b0;
        a4        = '0;
        b4        = '0;
        cin4      = 1'b0;
        sub4      = 1'b0;
        tag4      = '0;

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;

        directed("wrap",      32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 4'h3,
                 32'h0000_0000, 1'b1, 1'b0);
        directed("sub_neg",   32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 4'h4,
                 32'hFFFF_FFFE, 1'b0, 1'b0);
        directed("pos_ovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 4'h5,
                 32'h8000_0000, 1'b0, 1'b1);
        directed("sub_cin",   32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 4'h6,
                 32'hFFFF_FFFE, 1'b0, 1'b0);
        directed("cin_only",  32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 4'h7,
                 32'h0000_0001, 1'b0, 1'b0);
        directed("sub_ovf",   32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 4'h8,
                 32'h7FFF_FFFF, 1'b1, 1'b1);
        directed("sub_zero",  32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 4'h9,
                 32'h0000_0000, 1'b1, 1'b0);
        directed("neg_ovf",   32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 4'hA,
                 32'h0000_0000, 1'b1, 1'b1);
        directed("mixed",     32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, 4'hB,
                 32'hACF1_3569, 1'b0, 1'b0);

        // Back-to-back random stream at full rate.
        sb.delete();
        for (int i = 0; i < 103; i++) begin
            in_valid = (i < 100);
            a        = $urandom();
            b        = $urandom();
            r        = $urandom();
            cin      = r[0];
            sub      = r[1];
            in_tag   = 4'(i % 16);
            if (i >= 3) begin
                #1;
                check("stream_valid", 64'(out_valid), 64'(1));
            end
            tick(acc);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick(acc);
        check("stream_drained", 64'(sb.size()), 64'(0));

        // Fill the pipe, stall for 5 cycles, then drain.
        idx = 0;
        for (int cyc = 0; cyc < 40 && idx < 12; cyc++) begin
            out_ready = !(cyc >= 4 && cyc < 9);
            in_valid  = 1'b1;
            a         = 32'h0101_0101 * 32'(idx + 1);
            b         = 32'h0F0F_0F0F ^ 32'(idx);
            cin       = idx[0];
            sub       = idx[1];
            in_tag    = idx[3:0];
            if (!out_ready) begin
                #1;
                check("stall_in_ready", 64'(in_ready), 64'(0));
                check("stall_valid", 64'(out_valid), 64'(1));
                if (sb.size() > 0) begin
                    check("stall_sum", 64'(sum), 64'(sb[0].sum));
                    check("stall_tag", 64'(out_tag), 64'(sb[0].tag));
                end
            end
            tick(acc);
            if (acc) idx++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick(acc);
        check("stall_count", 64'(idx), 64'(12));
        check("stall_drained", 64'(sb.size()), 64'(0));

        // Reset with two beats in flight.
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            a      = 32'(i + 100);
            b      = 32'd1;
            in_tag = 4'(i + 1);
            tick(acc);
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_in_ready", 64'(in_ready), 64'(1));
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("post_rst_valid", 64'(out_valid), 64'(0));
            @(posedge clk);
            #1;
        end

        // Exhaustive 4-bit sweep over {sub, cin, b, a} for spacing 0, 1, 2.
        for (int c = 0; c < 1027; c++) begin
            v4   = (c < 1024);
            a4   = c[3:0];
            b4   = c[7:4];
            cin4 = c[8];
            sub4 = c[9];
            tag4 = c[3:0] ^ c[7:4];
            #1;
            for (int d = 0; d < 3; d++) begin
                j = c - lat4[d];
                if (j >= 0 && j < 1024) begin
                    m = model4(j);
                    check("w4_valid", 64'(vo4[d]), 64'(1));
                    check("w4_sum", 64'(s4[d]), 64'(m[3:0]));
                    check("w4_cout", 64'(co4[d]), 64'(m[4]));
                    check("w4_ovf", 64'(ov4[d]), 64'(m[5]));
                    check("w4_tag", 64'(to4[d]), 64'(j[3:0] ^ j[7:4]));
                end else begin
                    check("w4_idle", 64'(vo4[d]), 64'(0));
                end
            end
            @(posedge clk);
            #1;
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
